// File: rtl/dmem_pkg.sv
// Shared decode types, MMIO offsets and byte-lane helpers for the dmem responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } dmem_region_e;

  localparam logic [11:0] TOHOST_OFF      = 12'h000;
  localparam logic [11:0] CONSOLE_OFF     = 12'h004;
  localparam logic [11:0] CYCLE_LO_OFF    = 12'h008;
  localparam logic [11:0] CYCLE_HI_OFF    = 12'h00C;
  localparam logic [11:0] SCRATCH_OFF     = 12'h010;
  localparam logic [11:0] STORE_CNT_OFF   = 12'h014;
  localparam logic [11:0] STORE_BYTES_OFF = 12'h018;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  ben);
    logic [31:0] r;
    r = old;
    for (int unsigned k = 0; k < 4; k++) begin
      if (ben[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] ben);
    return {2'b00, ben[0]} + {2'b00, ben[1]} + {2'b00, ben[2]} + {2'b00, ben[3]};
  endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Word-organised RAM with per-byte write enables and a combinational read port.
module dmem_ram_bank #(
  parameter int unsigned MEM_BYTES = 4096,
  localparam int unsigned IW = (MEM_BYTES > 4) ? $clog2(MEM_BYTES) - 2 : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    ben_i,
  output logic [31:0]   rdata_o
);

  localparam int unsigned WORDS = MEM_BYTES / 4;

  logic [31:0] mem_q [WORDS];

  assign rdata_o = mem_q[idx_i];

  // Contents are deliberately not reset; software owns initialisation.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (ben_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side slave: byte-enable RAM plus MMIO window (tohost, console, cycle counter, scratch).
// Optional store counters at 0x14/0x18 are built only when DMEM_ACCESS_CNT_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic        dmem_wen_i,
  input  logic [3:0]  dmem_ben_i,
  output logic [31:0] dmem_rdata_o,
  output logic        halt_o,
  output logic [31:0] exit_code_o,
  output logic        putc_valid_o,
  output logic [7:0]  putc_data_o,
  output logic        unmapped_o
);

  localparam int unsigned IW        = (MEM_BYTES > 4) ? $clog2(MEM_BYTES) - 2 : 1;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  dmem_region_e region;
  logic [11:0]  off;
  logic         access, wr_act, ram_we, mmio_wr, off_bad;
  logic [31:0]  ram_rdata, mmio_rdata;

  logic         halt_q, halt_d;
  logic [31:0]  exit_code_q, exit_code_d;
  logic         putc_valid_q, putc_valid_d;
  logic [7:0]   putc_data_q, putc_data_d;
  logic         unmapped_q, unmapped_d;
  logic [63:0]  cycle_q, cycle_d;
  logic [31:0]  scratch_q, scratch_d;
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0]  store_cnt_q, store_cnt_d;
  logic [31:0]  store_bytes_q, store_bytes_d;
`endif

  always_comb begin
    if ({1'b0, dmem_addr_i} < MEM_LIMIT)              region = REG_RAM;
    else if (dmem_addr_i[31:12] == MMIO_BASE[31:12])  region = REG_MMIO;
    else                                              region = REG_UNMAPPED;
  end

  assign off     = {dmem_addr_i[11:2], 2'b00};
  // A write with no lanes enabled is a no-op and must not even flag unmapped.
  assign access  = !(dmem_wen_i && (dmem_ben_i == 4'b0000));
  assign wr_act  = dmem_wen_i && (dmem_ben_i != 4'b0000) && !rst_i;
  assign ram_we  = wr_act && (region == REG_RAM);
  assign mmio_wr = wr_act && (region == REG_MMIO);

  dmem_ram_bank #(
    .MEM_BYTES(MEM_BYTES)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .idx_i   (dmem_addr_i[IW+1:2]),
    .wdata_i (dmem_wdata_i),
    .ben_i   (dmem_ben_i),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    mmio_rdata = '0;
    off_bad    = 1'b0;
    case (off)
      TOHOST_OFF:      mmio_rdata = exit_code_q;
      CONSOLE_OFF:     mmio_rdata = '0;
      CYCLE_LO_OFF:    mmio_rdata = cycle_q[31:0];
      CYCLE_HI_OFF:    mmio_rdata = cycle_q[63:32];
      SCRATCH_OFF:     mmio_rdata = scratch_q;
`ifdef DMEM_ACCESS_CNT_EN
      STORE_CNT_OFF:   mmio_rdata = store_cnt_q;
      STORE_BYTES_OFF: mmio_rdata = store_bytes_q;
`endif
      default:         off_bad    = 1'b1;
    endcase
  end

  always_comb begin
    case (region)
      REG_RAM:  dmem_rdata_o = ram_rdata;
      REG_MMIO: dmem_rdata_o = mmio_rdata;
      default:  dmem_rdata_o = '0;
    endcase
  end

  always_comb begin
    halt_d       = halt_q;
    exit_code_d  = exit_code_q;
    putc_valid_d = 1'b0;
    putc_data_d  = putc_data_q;
    scratch_d    = scratch_q;
    // The halting edge still counts; freezing starts once halt_q is visible.
    cycle_d      = halt_q ? cycle_q : cycle_q + 64'd1;
    unmapped_d   = unmapped_q |
                   (access && ((region == REG_UNMAPPED) ||
                               ((region == REG_MMIO) && off_bad)));
`ifdef DMEM_ACCESS_CNT_EN
    store_cnt_d   = store_cnt_q;
    store_bytes_d = store_bytes_q;
    if (ram_we && !halt_q) begin
      store_cnt_d   = store_cnt_q + 32'd1;
      store_bytes_d = store_bytes_q + 32'(popcount4(dmem_ben_i));
    end
`endif
    if (mmio_wr) begin
      case (off)
        TOHOST_OFF: begin
          if (!halt_q) begin
            halt_d      = 1'b1;
            exit_code_d = dmem_wdata_i;
          end
        end
        CONSOLE_OFF: begin
          if (dmem_ben_i[0]) begin
            putc_valid_d = 1'b1;
            putc_data_d  = dmem_wdata_i[7:0];
          end
        end
        SCRATCH_OFF: scratch_d = byte_merge(scratch_q, dmem_wdata_i, dmem_ben_i);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_q        <= 1'b0;
      exit_code_q   <= '0;
      putc_valid_q  <= 1'b0;
      putc_data_q   <= '0;
      unmapped_q    <= 1'b0;
      cycle_q       <= '0;
      scratch_q     <= '0;
`ifdef DMEM_ACCESS_CNT_EN
      store_cnt_q   <= '0;
      store_bytes_q <= '0;
`endif
    end else begin
      halt_q        <= halt_d;
      exit_code_q   <= exit_code_d;
      putc_valid_q  <= putc_valid_d;
      putc_data_q   <= putc_data_d;
      unmapped_q    <= unmapped_d;
      cycle_q       <= cycle_d;
      scratch_q     <= scratch_d;
`ifdef DMEM_ACCESS_CNT_EN
      store_cnt_q   <= store_cnt_d;
      store_bytes_q <= store_bytes_d;
`endif
    end
  end

  assign halt_o       = halt_q;
  assign exit_code_o  = exit_code_q;
  assign putc_valid_o = putc_valid_q;
  assign putc_data_o  = putc_data_q;
  assign unmapped_o   = unmapped_q;

endmodule
